fibonacci_index: RTL and testbench



---
 rtl/fib_pkg.sv | 12 +
 rtl/fibonacci_index_if.sv | 23 ++
 rtl/fibonacci_index.sv | 102 ++++++++++
 tb/tb_fibonacci_index.sv | 118 +++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its inverse, fibonacci_index.
package fib_pkg;
    localparam int unsigned FIB_W       = 20;
    localparam int unsigned FIB_IDX_W   = 5;
    localparam int unsigned FIB_MAX_IDX = 30;

    typedef enum logic [1:0] {
        idle,
        op,
        done
    } state_t;
endpackage

// File: rtl/fibonacci_index_if.sv
// start/ready/done_tick handshake and result bus for fibonacci_index.
interface fibonacci_index_if #(
    parameter int unsigned FIB_W = fib_pkg::FIB_W,
    parameter int unsigned IDX_W = fib_pkg::FIB_IDX_W
);
    logic             start;
    logic [FIB_W-1:0] f;
    logic             ready;
    logic             done_tick;
    logic [IDX_W-1:0] idx;
    logic [FIB_W-1:0] fib_floor;
    logic             exact;

    modport master (
        output start, f,
        input  ready, done_tick, idx, fib_floor, exact
    );

    modport slave (
        input  start, f,
        output ready, done_tick, idx, fib_floor, exact
    );
endinterface

// File: rtl/fibonacci_index.sv
// Finds the largest n with F(n) <= f, one Fibonacci step per clock, and
// reports F(n) plus whether f is itself a Fibonacci number.
module fibonacci_index #(
    parameter int unsigned FIB_W = fib_pkg::FIB_W,
    parameter int unsigned IDX_W = fib_pkg::FIB_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    fibonacci_index_if.slave bus
);
    import fib_pkg::*;

    state_t           state_q, state_d;
    logic [FIB_W-1:0] f_q, f_d;
    logic [FIB_W-1:0] t0_q, t0_d;
    logic [FIB_W-1:0] t1_q, t1_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FIB_W-1:0] floor_q, floor_d;
    logic             exact_q, exact_d;
    logic [FIB_W:0]   sum;

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        n_d     = n_q;
        idx_d   = idx_q;
        floor_d = floor_q;
        exact_d = exact_q;
        // One extra bit so F(29)+F(30) cannot wrap below f.
        sum     = {1'b0, t0_q} + {1'b0, t1_q};

        case (state_q)
            idle: begin
                if (bus.start) begin
                    f_d     = bus.f;
                    t0_d    = '0;
                    t1_d    = FIB_W'(1);
                    n_d     = IDX_W'(1);
                    state_d = op;
                end
            end
            op: begin
                if (f_q == '0) begin
                    idx_d   = '0;
                    floor_d = '0;
                    exact_d = 1'b1;
                    state_d = done;
                end else if (sum <= {1'b0, f_q}) begin
                    t0_d = t1_q;
                    t1_d = sum[FIB_W-1:0];
                    n_d  = n_q + IDX_W'(1);
                end else begin
                    idx_d   = n_q;
                    floor_d = t1_q;
                    exact_d = (t1_q == f_q);
                    state_d = done;
                end
            end
            done:    state_d = idle;
            default: state_d = idle;
        endcase
    end

    always_comb begin
        bus.ready     = 1'b0;
        bus.done_tick = 1'b0;
        case (state_q)
            idle:    begin bus.ready = 1'b1; bus.done_tick = 1'b0; end
            op:      begin bus.ready = 1'b0; bus.done_tick = 1'b0; end
            done:    begin bus.ready = 1'b0; bus.done_tick = 1'b1; end
            default: begin bus.ready = 1'b0; bus.done_tick = 1'b0; end
        endcase
        bus.idx       = idx_q;
        bus.fib_floor = floor_q;
        bus.exact     = exact_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= idle;
            f_q     <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            floor_q <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            floor_q <= floor_d;
            exact_q <= exact_d;
        end
    end
endmodule

// File: tb/tb_fibonacci_index.sv
// Directed bench for fibonacci_index with hand-computed expected results.
module tb_fibonacci_index;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total  = 0;
    int   passes = 0;
    int   last_idx = 0;

    always #5 clk = ~clk;

    fibonacci_index_if #(.FIB_W(20), .IDX_W(5)) bus ();

    fibonacci_index #(.FIB_W(20), .IDX_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Launch one request; done_tick expected in cycle exp_done after the start edge.
    // inject > 0 pulses start with f=5 in that op cycle, which must be ignored.
    task automatic run(input logic [19:0] fv, input int exp_idx, input int exp_floor,
                       input int exp_exact, input int exp_done, input int inject);
        int cyc;
        bit busy_ok;
        check("ready_before_start", 32'(bus.ready), 1);
        bus.start = 1'b1;
        bus.f     = fv;
        tick;
        bus.start = 1'b0;
        bus.f     = ~fv;
        cyc       = 1;
        busy_ok   = 1'b1;
        check("idx_holds_during_op", 32'(bus.idx), 32'(last_idx));
        while (!bus.done_tick && cyc < 100) begin
            if (bus.ready) busy_ok = 1'b0;
            if (cyc == inject) begin
                bus.start = 1'b1;
                bus.f     = 20'd5;
            end
            tick;
            bus.start = 1'b0;
            cyc++;
        end
        check("done_cycle", 32'(cyc), 32'(exp_done));
        check("ready_low_in_op", 32'(busy_ok), 1);
        check("idx", 32'(bus.idx), 32'(exp_idx));
        check("fib_floor", 32'(bus.fib_floor), 32'(exp_floor));
        check("exact", 32'(bus.exact), 32'(exp_exact));
        tick;
        check("ready_after_done", 32'(bus.ready), 1);
        check("done_tick_single", 32'(bus.done_tick), 0);
        last_idx = exp_idx;
    endtask

    initial begin
        int   cyc;
        bit   saw_done;
        bus.start = 1'b0;
        bus.f     = '0;
        rst       = 1'b0;
        tick;
        tick;
        check("rst_ready", 32'(bus.ready), 1);
        check("rst_done_tick", 32'(bus.done_tick), 0);
        check("rst_idx", 32'(bus.idx), 0);
        check("rst_floor", 32'(bus.fib_floor), 0);
        check("rst_exact", 32'(bus.exact), 0);
        rst = 1'b1;
        tick;

        run(20'd0,       0,  0,      1, 2,  0);
        run(20'd1,       2,  1,      1, 3,  0);
        run(20'd2,       3,  2,      1, 4,  0);
        run(20'd100,     11, 89,     0, 12, 0);
        run(20'd832040,  30, 832040, 1, 31, 0);
        run(20'd1048575, 30, 832040, 0, 31, 0);
        run(20'd100,     11, 89,     0, 12, 3);
        run(20'd5,       5,  5,      1, 6,  0);

        // Abort a long request with reset in op cycle 10.
        check("abort_ready_before", 32'(bus.ready), 1);
        bus.start = 1'b1;
        bus.f     = 20'd832040;
        tick;
        bus.start = 1'b0;
        for (cyc = 1; cyc < 10; cyc++) tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("abort_ready", 32'(bus.ready), 1);
        check("abort_idx", 32'(bus.idx), 0);
        check("abort_floor", 32'(bus.fib_floor), 0);
        check("abort_exact", 32'(bus.exact), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_tick) saw_done = 1'b1;
            tick;
        end
        check("abort_no_done_tick", 32'(saw_done), 0);
        last_idx = 0;

        run(20'd13, 7, 13, 1, 8, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
